// File: rtl/request_encoder_16to4.sv
// Latches 16 request lines into sticky pending bits and presents one selected request
// per transfer as a registered binary index plus its one-hot image, under valid/ready.
module request_encoder_16to4 #(
    parameter int NUM_REQ     = 16,
    parameter int IDX_W       = 4,
    parameter int ROUND_ROBIN = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_bits,
    input  logic               flush,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [IDX_W-1:0]   out_index,
    output logic [NUM_REQ-1:0] out_onehot,
    output logic [NUM_REQ-1:0] pending_bits,
    output logic               busy
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [NUM_REQ-1:0] onehot_q, onehot_d;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] sel_oh;
    logic [IDX_W-1:0]   sel;
    logic               load;

    function automatic logic [IDX_W-1:0] pick_fixed(input logic [NUM_REQ-1:0] c);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (c[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Scan starts one past the last grant and wraps, so the last winner goes to the back.
    function automatic logic [IDX_W-1:0] pick_rr(input logic [NUM_REQ-1:0] c,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] r;
        logic [IDX_W-1:0] idx;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && c[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_REQ-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    always_comb begin
        cand = pend_q | req_bits;
        if (ROUND_ROBIN != 0) sel = pick_rr(cand, rr_ptr_q);
        else                  sel = pick_fixed(cand);
        sel_oh = decode(sel);
        load   = (cand != '0) && ((state_q == S_EMPTY) || out_ready);

        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        pend_d   = cand;
        onehot_d = onehot_q;

        if (flush) begin
            state_d  = S_EMPTY;
            pend_d   = '0;
            onehot_d = '0;
            rr_ptr_d = '1;
        end else if (load) begin
            // A request arriving with its own selection is removed here, so it is served once.
            state_d  = S_FULL;
            idx_d    = sel;
            onehot_d = sel_oh;
            pend_d   = cand & ~sel_oh;
            rr_ptr_d = sel;
        end else if ((state_q == S_FULL) && out_ready) begin
            state_d  = S_EMPTY;
            onehot_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_EMPTY;
            idx_q    <= '0;
            rr_ptr_q <= '1;
            pend_q   <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            pend_q   <= pend_d;
            onehot_q <= onehot_d;
        end
    end

    assign out_valid    = (state_q == S_FULL);
    assign out_index    = idx_q;
    assign out_onehot   = onehot_q;
    assign pending_bits = pend_q;
    assign busy         = (state_q == S_FULL) || (pend_q != '0);

endmodule
